// File: rtl/pipe_ctrl.sv
// Pipeline hazard/flush controller for a 5-stage MIPS-style pipe.
// Produces stage write enables and bubble flushes, tracks memory waits and exception masking.
module pipe_ctrl (
  input  logic        i_clk,
  input  logic        i_s_rst,
  input  logic [31:0] i_instr_dec,
  input  logic [31:0] i_instr_exec,
  input  logic        i_redirect,
  input  logic        i_exception,
  input  logic        i_mem_busy,
  output logic        o_we_pc,
  output logic        o_we_dec,
  output logic        o_we_exec,
  output logic        o_we_MemAc,
  output logic        o_we_WrBc,
  output logic        o_s_rst_dec,
  output logic        o_s_rst_exec,
  output logic        o_s_rst_MemAc,
  output logic        o_s_rst_WrBc,
  output logic [1:0]  o_state,
  output logic [15:0] o_stall_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    EXC_MASK = 2'd2
  } state_t;

  localparam logic [5:0] OP_LW = 6'b100011;

  state_t state;
  logic   pending;
  logic   mask_cnt;
  logic   from_mask;

  logic [4:0] rt_exec;
  logic       load_use;
  logic       in_mask;
  logic       exc_eff;

  assign rt_exec  = i_instr_exec[20:16];
  assign load_use = (i_instr_exec[31:26] == OP_LW) && (rt_exec != 5'd0) &&
                    ((rt_exec == i_instr_dec[25:21]) || (rt_exec == i_instr_dec[20:16]));

  // A wait entered from the mask window still belongs to that window.
  assign in_mask = (state == EXC_MASK) || ((state == MEM_WAIT) && from_mask);
  assign exc_eff = !in_mask && (i_exception || ((state == MEM_WAIT) && pending));

  assign o_state = i_s_rst ? RUN : state;

  always_comb begin
    // NOTE: every output gets a default first so no path through the priority chain infers a latch.
    o_we_pc       = 1'b1;
    o_we_dec      = 1'b1;
    o_we_exec     = 1'b1;
    o_we_MemAc    = 1'b1;
    o_we_WrBc     = 1'b1;
    o_s_rst_dec   = 1'b0;
    o_s_rst_exec  = 1'b0;
    o_s_rst_MemAc = 1'b0;
    o_s_rst_WrBc  = 1'b0;
    if (i_s_rst) begin
      o_we_pc       = 1'b0;
      o_we_dec      = 1'b0;
      o_we_exec     = 1'b0;
      o_we_MemAc    = 1'b0;
      o_we_WrBc     = 1'b0;
      o_s_rst_dec   = 1'b1;
      o_s_rst_exec  = 1'b1;
      o_s_rst_MemAc = 1'b1;
      o_s_rst_WrBc  = 1'b1;
    end else if (i_mem_busy) begin
      o_we_pc    = 1'b0;
      o_we_dec   = 1'b0;
      o_we_exec  = 1'b0;
      o_we_MemAc = 1'b0;
      o_we_WrBc  = 1'b0;
    end else if (exc_eff) begin
      // Handler vector loads into PC; the instruction in WriteBack retires.
      o_s_rst_dec   = 1'b1;
      o_s_rst_exec  = 1'b1;
      o_s_rst_MemAc = 1'b1;
    end else if (load_use) begin
      o_we_pc      = 1'b0;
      o_we_dec     = 1'b0;
      o_s_rst_exec = 1'b1;
    end else if (i_redirect) begin
      o_s_rst_dec = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (i_s_rst) begin
      state       <= RUN;
      pending     <= 1'b0;
      mask_cnt    <= 1'b0;
      from_mask   <= 1'b0;
      o_stall_cnt <= 16'd0;
    end else begin
      if (!o_we_pc && (o_stall_cnt != 16'hFFFF))
        o_stall_cnt <= o_stall_cnt + 16'd1;

      if (i_mem_busy) begin
        state <= MEM_WAIT;
        if (state != MEM_WAIT)
          from_mask <= (state == EXC_MASK);
        if (i_exception && !in_mask)
          pending <= 1'b1;
      end else begin
        pending   <= 1'b0;
        from_mask <= 1'b0;
        if (exc_eff) begin
          state    <= EXC_MASK;
          mask_cnt <= 1'b0;
        end else if (state == MEM_WAIT) begin
          // mask_cnt was frozen during the wait and resumes where it left off.
          state <= from_mask ? EXC_MASK : RUN;
        end else if (state == EXC_MASK) begin
          if (mask_cnt) begin
            state    <= RUN;
            mask_cnt <= 1'b0;
          end else begin
            mask_cnt <= 1'b1;
          end
        end else begin
          state <= RUN;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: table-driven cycle vectors compared through a scoreboard queue,
// plus a long busy sequence exercising stall-counter saturation.
module tb_pipe_ctrl;

  typedef struct {
    string       name;
    logic        rst;
    logic [31:0] dec;
    logic [31:0] exec;
    logic        redirect;
    logic        exception;
    logic        busy;
    logic [4:0]  we;
    logic [3:0]  srst;
    logic [1:0]  state;
    logic [15:0] cnt;
  } vec_t;

  localparam logic [4:0] WE_ALL  = 5'b11111;
  localparam logic [4:0] WE_NONE = 5'b00000;
  localparam logic [4:0] WE_LU   = 5'b00111;
  localparam logic [3:0] SR_NONE = 4'b0000;
  localparam logic [3:0] SR_ALL  = 4'b1111;
  localparam logic [3:0] SR_LU   = 4'b0100;
  localparam logic [3:0] SR_RD   = 4'b1000;
  localparam logic [3:0] SR_EXC  = 4'b1110;

  localparam logic [31:0] LW5     = 32'h8C05_0000;  // lw   $5, 0($0)
  localparam logic [31:0] LW0     = 32'h8C00_0000;  // lw   $0, 0($0)
  localparam logic [31:0] ADDI5   = 32'h2005_0000;  // addi $5, $0, 0
  localparam logic [31:0] ADD5    = 32'h00A7_3020;  // add  $6, $5, $7
  localparam logic [31:0] ADD_RT5 = 32'h00E5_3020;  // add  $6, $7, $5
  localparam logic [31:0] ADD0    = 32'h0007_3020;  // add  $6, $0, $7

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr_dec = '0;
  logic [31:0] instr_exec = '0;
  logic        redirect = 1'b0;
  logic        exception = 1'b0;
  logic        mem_busy = 1'b0;
  logic        we_pc, we_dec, we_exec, we_mem, we_wb;
  logic        srst_dec, srst_exec, srst_mem, srst_wb;
  logic [1:0]  state;
  logic [15:0] stall_cnt;

  int   errors = 0;
  int   checks = 0;
  vec_t exp_q[$];
  vec_t tbl[$];

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .i_clk         (clk),
    .i_s_rst       (rst),
    .i_instr_dec   (instr_dec),
    .i_instr_exec  (instr_exec),
    .i_redirect    (redirect),
    .i_exception   (exception),
    .i_mem_busy    (mem_busy),
    .o_we_pc       (we_pc),
    .o_we_dec      (we_dec),
    .o_we_exec     (we_exec),
    .o_we_MemAc    (we_mem),
    .o_we_WrBc     (we_wb),
    .o_s_rst_dec   (srst_dec),
    .o_s_rst_exec  (srst_exec),
    .o_s_rst_MemAc (srst_mem),
    .o_s_rst_WrBc  (srst_wb),
    .o_state       (state),
    .o_stall_cnt   (stall_cnt)
  );

  function automatic vec_t mk(input string n, input logic r, input logic [31:0] d,
                              input logic [31:0] e, input logic rd, input logic ex,
                              input logic bz, input logic [4:0] we, input logic [3:0] sr,
                              input logic [1:0] st, input logic [15:0] c);
    vec_t v;
    v.name = n; v.rst = r; v.dec = d; v.exec = e;
    v.redirect = rd; v.exception = ex; v.busy = bz;
    v.we = we; v.srst = sr; v.state = st; v.cnt = c;
    return v;
  endfunction

  task automatic check(input vec_t e);
    logic [26:0] act;
    logic [26:0] req;
    act = {we_pc, we_dec, we_exec, we_mem, we_wb,
           srst_dec, srst_exec, srst_mem, srst_wb, state, stall_cnt};
    req = {e.we, e.srst, e.state, e.cnt};
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got we=%b srst=%b state=%0d cnt=%h, want we=%b srst=%b state=%0d cnt=%h",
               e.name, act[26:22], act[21:18], act[17:16], act[15:0],
               e.we, e.srst, e.state, e.cnt);
    end
  endtask

  // One clock cycle: drive just after the rising edge, compare on the falling edge.
  task automatic apply(input vec_t v, input bit chk);
    @(posedge clk);
    #1;
    rst        = v.rst;
    instr_dec  = v.dec;
    instr_exec = v.exec;
    redirect   = v.redirect;
    exception  = v.exception;
    mem_busy   = v.busy;
    if (chk) exp_q.push_back(v);
    @(negedge clk);
    if (chk) check(exp_q.pop_front());
  endtask

  initial begin
    vec_t busy_v;

    // load-use stall, $0 and non-load exemptions, rt match, redirect deferred by stall
    tbl.push_back(mk("reset",         1, 0,       0,     0, 0, 0, WE_NONE, SR_ALL,  0, 16'd0));
    tbl.push_back(mk("lu_rs",         0, ADD5,    LW5,   0, 0, 0, WE_LU,   SR_LU,   0, 16'd0));
    tbl.push_back(mk("lu_cleared",    0, ADD5,    0,     0, 0, 0, WE_ALL,  SR_NONE, 0, 16'd1));
    tbl.push_back(mk("lw_r0",         0, ADD0,    LW0,   0, 0, 0, WE_ALL,  SR_NONE, 0, 16'd1));
    tbl.push_back(mk("addi_no_lu",    0, ADD5,    ADDI5, 0, 0, 0, WE_ALL,  SR_NONE, 0, 16'd1));
    tbl.push_back(mk("lu_rt",         0, ADD_RT5, LW5,   0, 0, 0, WE_LU,   SR_LU,   0, 16'd1));
    tbl.push_back(mk("lu_rt_cleared", 0, ADD_RT5, 0,     0, 0, 0, WE_ALL,  SR_NONE, 0, 16'd2));
    tbl.push_back(mk("lu_over_redir", 0, ADD5,    LW5,   1, 0, 0, WE_LU,   SR_LU,   0, 16'd2));
    tbl.push_back(mk("redir_retry",   0, ADD5,    0,     1, 0, 0, WE_ALL,  SR_RD,   0, 16'd3));
    tbl.push_back(mk("idle",          0, 0,       0,     0, 0, 0, WE_ALL,  SR_NONE, 0, 16'd3));
    // exception and mask window
    tbl.push_back(mk("exc_run",       0, 0,       0,     0, 1, 0, WE_ALL,  SR_EXC,  0, 16'd3));
    tbl.push_back(mk("exc_masked",    0, 0,       0,     0, 1, 0, WE_ALL,  SR_NONE, 2, 16'd3));
    tbl.push_back(mk("lu_in_mask",    0, ADD5,    LW5,   0, 0, 0, WE_LU,   SR_LU,   2, 16'd3));
    tbl.push_back(mk("mask_done",     0, 0,       0,     0, 0, 0, WE_ALL,  SR_NONE, 0, 16'd4));
    // busy with pending exception
    tbl.push_back(mk("reset2",        1, 0,       0,     0, 0, 0, WE_NONE, SR_ALL,  0, 16'd4));
    tbl.push_back(mk("busy1",         0, 0,       0,     0, 0, 1, WE_NONE, SR_NONE, 0, 16'd0));
    tbl.push_back(mk("busy2_exc",     0, 0,       0,     0, 1, 1, WE_NONE, SR_NONE, 1, 16'd1));
    tbl.push_back(mk("busy3",         0, 0,       0,     0, 0, 1, WE_NONE, SR_NONE, 1, 16'd2));
    tbl.push_back(mk("busy_drop_exc", 0, 0,       0,     0, 0, 0, WE_ALL,  SR_EXC,  1, 16'd3));
    tbl.push_back(mk("pend_mask1",    0, 0,       0,     0, 0, 0, WE_ALL,  SR_NONE, 2, 16'd3));
    tbl.push_back(mk("pend_mask2",    0, 0,       0,     0, 0, 0, WE_ALL,  SR_NONE, 2, 16'd3));
    tbl.push_back(mk("pend_run",      0, 0,       0,     0, 0, 0, WE_ALL,  SR_NONE, 0, 16'd3));
    // reset during a wait
    tbl.push_back(mk("busy_pre_rst",  0, 0,       0,     0, 0, 1, WE_NONE, SR_NONE, 0, 16'd3));
    tbl.push_back(mk("rst_in_wait",   1, 0,       0,     0, 0, 1, WE_NONE, SR_ALL,  0, 16'd4));
    tbl.push_back(mk("run_after_rst", 0, 0,       0,     0, 0, 0, WE_ALL,  SR_NONE, 0, 16'd0));
    // wait inside the mask window: exception stays ignored, remaining mask resumes
    tbl.push_back(mk("exc_b",         0, 0,       0,     0, 1, 0, WE_ALL,  SR_EXC,  0, 16'd0));
    tbl.push_back(mk("busy_in_mask",  0, 0,       0,     0, 0, 1, WE_NONE, SR_NONE, 2, 16'd0));
    tbl.push_back(mk("drop_exc_ign",  0, 0,       0,     0, 1, 0, WE_ALL,  SR_NONE, 1, 16'd1));
    tbl.push_back(mk("resume_mask1",  0, 0,       0,     0, 0, 0, WE_ALL,  SR_NONE, 2, 16'd1));
    tbl.push_back(mk("resume_mask2",  0, 0,       0,     0, 0, 0, WE_ALL,  SR_NONE, 2, 16'd1));
    tbl.push_back(mk("resume_run",    0, 0,       0,     0, 0, 0, WE_ALL,  SR_NONE, 0, 16'd1));
    // exception outranks load-use and redirect
    tbl.push_back(mk("exc_prio",      0, ADD5,    LW5,   1, 1, 0, WE_ALL,  SR_EXC,  0, 16'd1));
    tbl.push_back(mk("prio_mask1",    0, 0,       0,     0, 0, 0, WE_ALL,  SR_NONE, 2, 16'd1));
    tbl.push_back(mk("prio_mask2",    0, 0,       0,     0, 0, 0, WE_ALL,  SR_NONE, 2, 16'd1));
    tbl.push_back(mk("prio_run",      0, 0,       0,     0, 0, 0, WE_ALL,  SR_NONE, 0, 16'd1));

    repeat (2) @(posedge clk);
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], 1'b1);

    // Saturation: fill the counter to FFFE with busy cycles, then three more stalls.
    apply(mk("sat_reset", 1, 0, 0, 0, 0, 0, WE_NONE, SR_ALL, 0, 16'd1), 1'b1);
    busy_v = mk("fill", 0, 0, 0, 0, 0, 1, WE_NONE, SR_NONE, 1, 16'd0);
    for (int i = 0; i < 65534; i++) apply(busy_v, 1'b0);
    apply(mk("sat_fffe",  0, 0, 0, 0, 0, 1, WE_NONE, SR_NONE, 1, 16'hFFFE), 1'b1);
    apply(mk("sat_ffff1", 0, 0, 0, 0, 0, 1, WE_NONE, SR_NONE, 1, 16'hFFFF), 1'b1);
    apply(mk("sat_ffff2", 0, 0, 0, 0, 0, 1, WE_NONE, SR_NONE, 1, 16'hFFFF), 1'b1);
    apply(mk("sat_held",  0, 0, 0, 0, 0, 0, WE_ALL,  SR_NONE, 1, 16'hFFFF), 1'b1);
    apply(mk("sat_run",   0, 0, 0, 0, 0, 0, WE_ALL,  SR_NONE, 0, 16'hFFFF), 1'b1);
    apply(mk("sat_clear", 1, 0, 0, 0, 0, 0, WE_NONE, SR_ALL,  0, 16'hFFFF), 1'b1);
    apply(mk("sat_zero",  0, 0, 0, 0, 0, 0, WE_ALL,  SR_NONE, 0, 16'd0), 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
